// File: rtl/display_timing_pkg.sv
// Shared display timing constants, horizontal phase type and sync-level helper
// for the scan sequencer and future frame-level blocks.
package display_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam logic        SYNC_POL_DEF = 1'b0;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        H_ACT   = 2'd0,
        H_FRONT = 2'd1,
        H_SYNC  = 2'd2,
        H_BACK  = 2'd3
    } hstate_t;

    // Drive level of a sync line: pol when asserted, its complement otherwise.
    function automatic logic sync_level(input logic pol, input logic asserted);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/scan_timing_ctrl_if.sv
// Scan sequencer <-> line counter / video path signal bundle.
interface scan_timing_ctrl_if;
    import display_timing_pkg::*;

    logic               PixEn;
    logic [COORD_W-1:0] LineIn;
    logic [COORD_W-1:0] PixelX;
    logic               HSync;
    logic               VSync;
    logic               Active;
    logic               IncLine;
    logic               FrameClr;

    modport master (
        output PixEn, LineIn,
        input  PixelX, HSync, VSync, Active, IncLine, FrameClr
    );

    modport slave (
        input  PixEn, LineIn,
        output PixelX, HSync, VSync, Active, IncLine, FrameClr
    );

endinterface

// File: rtl/scan_timing_ctrl.sv
// Horizontal scan sequencer: column counter, horizontal phase FSM, sync/active
// decode and the per-line IncLine / FrameClr pulses for the line counter.
module scan_timing_ctrl
    import display_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic              clk,
    input  logic              ResetLine,
    scan_timing_ctrl_if.slave bus
);

    localparam int unsigned LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] ACT_END  = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] FP_END   = COORD_W'(H_ACTIVE + H_FP - 1);
    localparam logic [COORD_W-1:0] SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] LINE_END = COORD_W'(LINE_LEN - 1);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(FRAME_LEN - 1);

    if (LINE_LEN > 1024 || FRAME_LEN > 1024) begin : g_cfg_err
        $error("scan_timing_ctrl: line or frame total exceeds the 10-bit coordinate range");
    end

    hstate_t            state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic               inc_q, inc_d;
    logic               clr_q, clr_d;

    // Next column, phase and outputs; outputs decode the state being entered.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        hsync_d  = hsync_q;
        active_d = active_q;
        inc_d    = 1'b0;
        clr_d    = 1'b0;
        vsync_d  = sync_level(SYNC_POL, (bus.LineIn >= VS_FIRST) && (bus.LineIn <= VS_LAST));

        if (bus.PixEn) begin
            x_d = (x_q == LINE_END) ? '0 : x_q + COORD_W'(1);

            case (state_q)
                H_ACT:   if (x_q == ACT_END)  state_d = H_FRONT;
                H_FRONT: if (x_q == FP_END)   state_d = display_timing_pkg::H_SYNC;
                display_timing_pkg::H_SYNC:
                         if (x_q == SYNC_END) state_d = H_BACK;
                H_BACK:  if (x_q == LINE_END) state_d = H_ACT;
                default:                      state_d = H_ACT;
            endcase

            hsync_d  = sync_level(SYNC_POL, state_d == display_timing_pkg::H_SYNC);
            active_d = (state_d == H_ACT) && (bus.LineIn < V_VIS);

            // Last line (or an out-of-range line number) wraps the frame.
            if (x_q == LINE_END) begin
                if (bus.LineIn >= V_LAST) clr_d = 1'b1;
                else                      inc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge ResetLine) begin
        if (ResetLine) begin
            state_q  <= H_ACT;
            x_q      <= '0;
            hsync_q  <= sync_level(SYNC_POL, 1'b0);
            vsync_q  <= sync_level(SYNC_POL, 1'b0);
            active_q <= 1'b0;
            inc_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            inc_q    <= inc_d;
            clr_q    <= clr_d;
        end
    end

    assign bus.PixelX   = x_q;
    assign bus.HSync    = hsync_q;
    assign bus.VSync    = vsync_q;
    assign bus.Active   = active_q;
    assign bus.IncLine  = inc_q;
    assign bus.FrameClr = clr_q;

endmodule

// File: tb/tb_scan_timing_ctrl.sv
// Directed bench: default 800x525 timing driven with hand-set line numbers, and
// a reduced 8-tick line instance closed through a line-counter model.
module tb_scan_timing_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    scan_timing_ctrl_if if_a ();
    scan_timing_ctrl_if if_b ();

    scan_timing_ctrl u_a (
        .clk       (clk),
        .ResetLine (rst_a),
        .bus       (if_a)
    );

    scan_timing_ctrl #(
        .H_ACTIVE (4),
        .H_FP     (1),
        .H_SYNC   (2),
        .H_BP     (1)
    ) u_b (
        .clk       (clk),
        .ResetLine (rst_b),
        .bus       (if_b)
    );

    // Line counter for the small instance; FrameClr clears it on the next clk.
    logic [9:0] lc;
    always @(posedge clk or posedge rst_b) begin
        if (rst_b)              lc <= 10'd0;
        else if (if_b.FrameClr) lc <= 10'd0;
        else if (if_b.IncLine)  lc <= lc + 10'd1;
    end
    assign if_b.LineIn = lc;

    int n_assert = 0;
    int n_fail   = 0;

    int   ex_a, ex_b;
    logic ea_hs, ea_act, ea_inc, ea_clr;
    logic eb_hs, eb_act, eb_inc, eb_clr;
    int   cnt_inc, cnt_clr, cnt_hs_low, cnt_vs_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic en);
        int prev;
        int ln;
        if_a.PixEn = en;
        ln = int'(if_a.LineIn);
        @(negedge clk);
        if (en) begin
            prev   = ex_a;
            ex_a   = (ex_a + 1) % 800;
            ea_hs  = !(ex_a >= 656 && ex_a < 752);
            ea_act = (ex_a < 640) && (ln < 480);
            ea_inc = (prev == 799) && (ln < 524);
            ea_clr = (prev == 799) && (ln >= 524);
        end else begin
            ea_inc = 1'b0;
            ea_clr = 1'b0;
        end
        chk("A.PixelX",   32'(if_a.PixelX),   32'(ex_a));
        chk("A.HSync",    32'(if_a.HSync),    32'(ea_hs));
        chk("A.Active",   32'(if_a.Active),   32'(ea_act));
        chk("A.IncLine",  32'(if_a.IncLine),  32'(ea_inc));
        chk("A.FrameClr", 32'(if_a.FrameClr), 32'(ea_clr));
        chk("A.VSync",    32'(if_a.VSync),    32'(!(ln >= 490 && ln < 492)));
        if (if_a.IncLine)  cnt_inc++;
        if (if_a.FrameClr) cnt_clr++;
        if (!if_a.HSync)   cnt_hs_low++;
    endtask

    task automatic step_b();
        int prev;
        int ln;
        if_b.PixEn = 1'b1;
        ln = int'(lc);
        @(negedge clk);
        prev   = ex_b;
        ex_b   = (ex_b + 1) % 8;
        eb_hs  = !(ex_b >= 5 && ex_b <= 6);
        eb_act = (ex_b < 4) && (ln < 480);
        eb_inc = (prev == 7) && (ln < 524);
        eb_clr = (prev == 7) && (ln >= 524);
        chk("B.PixelX",   32'(if_b.PixelX),   32'(ex_b));
        chk("B.HSync",    32'(if_b.HSync),    32'(eb_hs));
        chk("B.Active",   32'(if_b.Active),   32'(eb_act));
        chk("B.IncLine",  32'(if_b.IncLine),  32'(eb_inc));
        chk("B.FrameClr", 32'(if_b.FrameClr), 32'(eb_clr));
        chk("B.VSync",    32'(if_b.VSync),    32'(!(ln >= 490 && ln < 492)));
        if (if_b.IncLine)  cnt_inc++;
        if (if_b.FrameClr) cnt_clr++;
        if (!if_b.VSync)   cnt_vs_low++;
    endtask

    // Assert reset at a negedge, check it asynchronously and across one posedge.
    task automatic reset_a();
        rst_a = 1'b1;
        #1;
        chk("A.rst.PixelX",   32'(if_a.PixelX),   32'd0);
        chk("A.rst.HSync",    32'(if_a.HSync),    32'd1);
        chk("A.rst.VSync",    32'(if_a.VSync),    32'd1);
        chk("A.rst.Active",   32'(if_a.Active),   32'd0);
        chk("A.rst.IncLine",  32'(if_a.IncLine),  32'd0);
        chk("A.rst.FrameClr", 32'(if_a.FrameClr), 32'd0);
        @(negedge clk);
        chk("A.rst2.PixelX",  32'(if_a.PixelX),   32'd0);
        chk("A.rst2.IncLine", 32'(if_a.IncLine),  32'd0);
        chk("A.rst2.FrameClr",32'(if_a.FrameClr), 32'd0);
        rst_a  = 1'b0;
        ex_a   = 0;
        ea_hs  = 1'b1;
        ea_act = 1'b0;
        ea_inc = 1'b0;
        ea_clr = 1'b0;
    endtask

    initial begin
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        if_a.PixEn  = 1'b0;
        if_a.LineIn = 10'd0;
        if_b.PixEn  = 1'b0;
        repeat (3) @(negedge clk);

        // Continuous PixEn, line 0: two full lines.
        reset_a();
        if_a.PixEn = 1'b1;
        cnt_inc = 0; cnt_clr = 0; cnt_hs_low = 0;
        for (int i = 0; i < 1600; i++) step_a(1'b1);
        chk("A.p1.inc_count",   32'(cnt_inc),    32'd2);
        chk("A.p1.clr_count",   32'(cnt_clr),    32'd0);
        chk("A.p1.hsync_low",   32'(cnt_hs_low), 32'd192);

        // Reset in the middle of a line, then one clean line.
        for (int i = 0; i < 300; i++) step_a(1'b1);
        chk("A.mid.PixelX", 32'(if_a.PixelX), 32'd300);
        reset_a();
        cnt_inc = 0;
        for (int i = 0; i < 800; i++) step_a(1'b1);
        chk("A.mid.inc_count", 32'(cnt_inc), 32'd1);

        // One PixEn tick in four: two lines take 6400 clks.
        cnt_inc = 0; cnt_clr = 0;
        for (int i = 0; i < 1600; i++) begin
            step_a(1'b1);
            step_a(1'b0);
            step_a(1'b0);
            step_a(1'b0);
        end
        chk("A.div4.inc_count", 32'(cnt_inc), 32'd2);
        chk("A.div4.clr_count", 32'(cnt_clr), 32'd0);

        // Out-of-range line number forces a frame clear.
        if_a.LineIn = 10'd700;
        cnt_inc = 0; cnt_clr = 0;
        for (int i = 0; i < 800; i++) step_a(1'b1);
        chk("A.oor.inc_count", 32'(cnt_inc), 32'd0);
        chk("A.oor.clr_count", 32'(cnt_clr), 32'd1);

        // Vertical sync line on the default instance.
        if_a.LineIn = 10'd490;
        cnt_inc = 0;
        for (int i = 0; i < 800; i++) step_a(1'b1);
        chk("A.vs.inc_count", 32'(cnt_inc), 32'd1);
        if_a.PixEn = 1'b0;

        // Reduced instance closed through the line counter: one full frame.
        rst_b = 1'b1;
        #1;
        chk("B.rst.PixelX", 32'(if_b.PixelX), 32'd0);
        chk("B.rst.HSync",  32'(if_b.HSync),  32'd1);
        chk("B.rst.Active", 32'(if_b.Active), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        ex_b  = 0;
        cnt_inc = 0; cnt_clr = 0; cnt_vs_low = 0;
        for (int i = 0; i < 4201; i++) step_b();
        chk("B.frame.inc_count", 32'(cnt_inc),    32'd524);
        chk("B.frame.clr_count", 32'(cnt_clr),    32'd1);
        chk("B.frame.vsync_low", 32'(cnt_vs_low), 32'd16);
        chk("B.frame.line_wrap", 32'(lc),         32'd0);
        if_b.PixEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
